// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, forward selects,
// branch and M-extension funct3 codes, and the mul/div FSM states.
package exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/execute_stage_m_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
interface execute_stage_m_if #(
    parameter int XLEN = 32
);
    logic            regwriteE, memrwE, bselE, brunE, branchE, jumpE, jalrE, mdE;
    logic [2:0]      funct3E;
    logic [1:0]      wbselE;
    logic [3:0]      ALUselE;
    logic [1:0]      forwardAE, forwardBE;
    logic [4:0]      rdE;
    logic [XLEN-1:0] rd1E, rd2E, imm_exE, pcE, pc4E, resultW;

    logic            md_busyE, pcselE;
    logic [XLEN-1:0] pcTargetE;
    logic            regwriteM, memrwM;
    logic [1:0]      wbselM;
    logic [4:0]      rdM;
    logic [XLEN-1:0] ALUresM, data_writeM, pc4M;

    modport master (
        output regwriteE, memrwE, bselE, brunE, branchE, jumpE, jalrE, mdE,
        output funct3E, wbselE, ALUselE, forwardAE, forwardBE, rdE,
        output rd1E, rd2E, imm_exE, pcE, pc4E, resultW,
        input  md_busyE, pcselE, pcTargetE,
        input  regwriteM, memrwM, wbselM, rdM, ALUresM, data_writeM, pc4M
    );

    modport slave (
        input  regwriteE, memrwE, bselE, brunE, branchE, jumpE, jalrE, mdE,
        input  funct3E, wbselE, ALUselE, forwardAE, forwardBE, rdE,
        input  rd1E, rd2E, imm_exE, pcE, pc4E, resultW,
        output md_busyE, pcselE, pcTargetE,
        output regwriteM, memrwM, wbselM, rdM, ALUresM, data_writeM, pc4M
    );
endinterface

// File: rtl/md_unit.sv
// RV32M multiply/divide unit: captured-operand multiplier and radix-2 restoring divider.
// Optional macro EXEC_DIV_EARLY_OUT_EN: divide-by-zero / signed overflow skip the iterations.
module md_unit
    import exec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int            CW       = $clog2(XLEN);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] MUL_INIT = CW'((MUL_CYCLES >= 2) ? MUL_CYCLES - 2 : 0);
    localparam logic          MUL_COMB = (MUL_CYCLES == 1);

    md_state_e       state, state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_p0;
    logic [XLEN-1:0] a_p0, b_p0, quo, rem, dvs;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] q_fix, r_fix, div_res, mul_res;
    logic            early;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    function automatic logic div_ovf(input logic [2:0] f, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        return !f[0] && (x == {1'b1, {(XLEN-1){1'b0}}}) && (y == {XLEN{1'b1}});
    endfunction

    // Sign-extending to 2*XLEN makes the low half of one unsigned product exact for all variants.
    function automatic logic [XLEN-1:0] mul_result(input logic [2:0] f, input logic [XLEN-1:0] x,
                                                   input logic [XLEN-1:0] y);
        logic            sx, sy;
        logic [2*XLEN-1:0] xe, ye, p;
        sx = ((f == MD_MULH) || (f == MD_MULHSU)) && x[XLEN-1];
        sy = (f == MD_MULH) && y[XLEN-1];
        xe = {{XLEN{sx}}, x};
        ye = {{XLEN{sy}}, y};
        p  = xe * ye;
        return (f == MD_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

`ifdef EXEC_DIV_EARLY_OUT_EN
    assign early = (b == '0) || div_ovf(op, a, b);
`else
    assign early = 1'b0;
`endif

    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs};

    always_comb begin
        state_nx = state;
        busy     = rst_n && start && (state != S_DONE) && !(!op[2] && MUL_COMB);
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        done = MUL_COMB;
                        if (MUL_CYCLES == 2)     state_nx = S_DONE;
                        else if (MUL_CYCLES > 2) state_nx = S_MUL;
                    end else begin
                        state_nx = early ? S_DONE : S_DIV;
                    end
                end
            end
            S_MUL:   if (cnt == CW'(1)) state_nx = S_DONE;
            S_DIV:   if (cnt == '0)     state_nx = S_DONE;
            default: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        q_fix = (!op_p0[0] && (a_p0[XLEN-1] ^ b_p0[XLEN-1])) ? -quo : quo;
        r_fix = (!op_p0[0] && a_p0[XLEN-1]) ? -rem : rem;
        if (b_p0 == '0) begin
            q_fix = '1;
            r_fix = a_p0;
        end else if (div_ovf(op_p0, a_p0, b_p0)) begin
            q_fix = a_p0;
            r_fix = '0;
        end
        div_res = op_p0[1] ? r_fix : q_fix;
        mul_res = MUL_COMB ? mul_result(op, a, b) : mul_result(op_p0, a_p0, b_p0);
        result  = (state == S_DONE && op_p0[2]) ? div_res : mul_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_p0 <= '0;
            a_p0  <= '0;
            b_p0  <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                // Operands are frozen here because forwarded sources move during the stall.
                S_IDLE: begin
                    if (start) begin
                        op_p0 <= op;
                        a_p0  <= a;
                        b_p0  <= b;
                        cnt   <= op[2] ? DIV_LAST : MUL_INIT;
                        quo   <= magnitude(a, !op[0]);
                        dvs   <= magnitude(b, !op[0]);
                        rem   <= '0;
                    end
                end
                S_MUL: cnt <= cnt - CW'(1);
                S_DIV: begin
                    cnt <= cnt - CW'(1);
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage_m.sv
// Execute stage with ALU, branch resolve, RV32M unit and the EX/MEM register.
// Optional macro EXEC_DIV_EARLY_OUT_EN is consumed by md_unit.
module execute_stage_m
    import exec_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              MUL_CYCLES = 2,
    parameter logic [XLEN-1:0] RST_PC4    = '0
) (
    input logic              clk,
    input logic              rst_n,
    execute_stage_m_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] src_a, src_b_raw, src_b, alu_res, md_res, jalr_sum;
    logic            md_busy, md_done, br_taken;

    function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] f, input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] w, input logic [XLEN-1:0] m);
        case (f)
            FWD_W:   return w;
            FWD_M:   return m;
            default: return rf;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu(input logic [3:0] sel, input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y);
        logic [SHW-1:0] sh;
        sh = y[SHW-1:0];
        case (sel)
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_AND:  return x & y;
            ALU_OR:   return x | y;
            ALU_XOR:  return x ^ y;
            ALU_SLL:  return x << sh;
            ALU_SRL:  return x >> sh;
            ALU_SRA:  return $unsigned($signed(x) >>> sh);
            ALU_SLT:  return {{(XLEN-1){1'b0}}, $signed(x) < $signed(y)};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, x < y};
            default:  return '0;
        endcase
    endfunction

    function automatic logic br_cond(input logic [2:0] f, input logic uns, input logic [XLEN-1:0] x,
                                     input logic [XLEN-1:0] y);
        logic lt;
        lt = (uns || f[1]) ? (x < y) : ($signed(x) < $signed(y));
        case (f)
            BR_BEQ:           return x == y;
            BR_BNE:           return x != y;
            BR_BLT, BR_BLTU:  return lt;
            BR_BGE, BR_BGEU:  return !lt;
            default:          return 1'b0;
        endcase
    endfunction

    assign src_a     = fwd_sel(bus.forwardAE, bus.rd1E, bus.resultW, bus.ALUresM);
    assign src_b_raw = fwd_sel(bus.forwardBE, bus.rd2E, bus.resultW, bus.ALUresM);
    assign src_b     = bus.bselE ? bus.imm_exE : src_b_raw;
    assign alu_res   = alu(bus.ALUselE, src_a, src_b);
    assign br_taken  = br_cond(bus.funct3E, bus.brunE, src_a, src_b_raw);
    assign jalr_sum  = src_a + bus.imm_exE;

    assign bus.pcselE    = !bus.mdE && ((bus.branchE && br_taken) || bus.jumpE);
    assign bus.pcTargetE = bus.jalrE ? {jalr_sum[XLEN-1:1], 1'b0} : bus.pcE + bus.imm_exE;
    assign bus.md_busyE  = md_busy;

    md_unit #(
        .XLEN      (XLEN),
        .MUL_CYCLES(MUL_CYCLES)
    ) u_md (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bus.mdE),
        .op    (bus.funct3E),
        .a     (src_a),
        .b     (src_b_raw),
        .busy  (md_busy),
        .done  (md_done),
        .result(md_res)
    );

    // EX/MEM boundary: a bubble is loaded while the md unit holds EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.regwriteM   <= 1'b0;
            bus.memrwM      <= 1'b0;
            bus.wbselM      <= '0;
            bus.rdM         <= '0;
            bus.ALUresM     <= '0;
            bus.data_writeM <= '0;
            bus.pc4M        <= RST_PC4;
        end else if (md_busy) begin
            bus.regwriteM   <= 1'b0;
            bus.memrwM      <= 1'b0;
            bus.wbselM      <= '0;
            bus.rdM         <= '0;
            bus.ALUresM     <= '0;
            bus.data_writeM <= '0;
            bus.pc4M        <= '0;
        end else begin
            bus.regwriteM   <= bus.regwriteE;
            bus.memrwM      <= bus.memrwE;
            bus.wbselM      <= bus.wbselE;
            bus.rdM         <= bus.rdE;
            bus.ALUresM     <= (bus.mdE && md_done) ? md_res : alu_res;
            bus.data_writeM <= src_b_raw;
            bus.pc4M        <= bus.pc4E;
        end
    end

endmodule

// File: tb/tb_execute_stage_m.sv
// Table-driven, scoreboarded bench for execute_stage_m (XLEN=32, MUL_CYCLES=2).
module tb_execute_stage_m;
    import exec_pkg::*;

    localparam logic [31:0] PC    = 32'h0000_0100;
    localparam logic [31:0] RES_W = 32'd50;
    localparam int          DIV_BUSY = 33;
`ifdef EXEC_DIV_EARLY_OUT_EN
    localparam int          SPECIAL_BUSY = 1;
`else
    localparam int          SPECIAL_BUSY = 33;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_stage_m_if #(.XLEN(32)) bus ();

    execute_stage_m #(
        .XLEN      (32),
        .MUL_CYCLES(2),
        .RST_PC4   (32'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]  alusel;
        logic        md;
        logic [2:0]  f3;
        logic        br, jmp, jalr, bsel;
        logic [1:0]  fwda, fwdb;
        logic [31:0] a, b, imm, res;
        logic        pcsel;
        logic [31:0] tgt;
        int          busy;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  wbsel;
        logic [31:0] res;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] alusel, input logic md, input logic [2:0] f3,
                                input logic br, input logic jmp, input logic jalr, input logic bsel,
                                input logic [1:0] fwda, input logic [1:0] fwdb,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] res, input logic pcsel, input logic [31:0] tgt,
                                input int busy);
        vec_t v;
        v.alusel = alusel; v.md = md; v.f3 = f3; v.br = br; v.jmp = jmp; v.jalr = jalr;
        v.bsel = bsel; v.fwda = fwda; v.fwdb = fwdb; v.a = a; v.b = b; v.imm = imm;
        v.res = res; v.pcsel = pcsel; v.tgt = tgt; v.busy = busy;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic [4:0] rd, input logic [1:0] wb);
        bus.regwriteE = 1'b1;
        bus.memrwE    = 1'b0;
        bus.bselE     = v.bsel;
        bus.brunE     = 1'b0;
        bus.branchE   = v.br;
        bus.jumpE     = v.jmp;
        bus.jalrE     = v.jalr;
        bus.mdE       = v.md;
        bus.funct3E   = v.f3;
        bus.wbselE    = wb;
        bus.ALUselE   = v.alusel;
        bus.forwardAE = v.fwda;
        bus.forwardBE = v.fwdb;
        bus.rdE       = rd;
        bus.rd1E      = v.a;
        bus.rd2E      = v.b;
        bus.imm_exE   = v.imm;
        bus.pcE       = PC;
        bus.pc4E      = PC + 32'd4;
        bus.resultW   = RES_W;
    endtask

    task automatic run_op(input string name, input vec_t v, input logic [4:0] rd, input logic [1:0] wb);
        exp_t e, got;
        int   busy_cnt;
        drive(v, rd, wb);
        e.rd = rd; e.wbsel = wb; e.res = v.res;
        sb.push_back(e);
        #1;
        check({name, ".pcsel"}, {31'b0, bus.pcselE}, {31'b0, v.pcsel});
        if (v.pcsel) check({name, ".target"}, bus.pcTargetE, v.tgt);
        busy_cnt = 0;
        while (bus.md_busyE === 1'b1 && busy_cnt < 200) begin
            busy_cnt++;
            @(posedge clk); #1;
            check({name, ".bubble"}, {31'b0, bus.regwriteM}, 32'h0);
        end
        check({name, ".busy_cycles"}, busy_cnt, v.busy);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s.scoreboard: got output, expected empty queue", name);
        end else begin
            got = sb.pop_front();
            check({name, ".result"},   bus.ALUresM, got.res);
            check({name, ".rd"},       {27'b0, bus.rdM}, {27'b0, got.rd});
            check({name, ".wbsel"},    {30'b0, bus.wbselM}, {30'b0, got.wbsel});
            check({name, ".regwrite"}, {31'b0, bus.regwriteM}, 32'h1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // Reset with an md op pending: busy must stay low, EX/MEM cleared.
        drive(mk(ALU_ADD, 1'b1, MD_DIV, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 1, 1, 0, 0, 0, 0, 0), 5'd1, 2'd0);
        #12;
        check("reset.busy",     {31'b0, bus.md_busyE}, 32'h0);
        check("reset.regwrite", {31'b0, bus.regwriteM}, 32'h0);
        check("reset.alures",   bus.ALUresM, 32'h0);
        check("reset.pc4",      bus.pc4M, 32'h0);
        bus.mdE = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back(mk(ALU_ADD,  0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 60, 40, 0, 100, 0, 0, 0));
        vecs.push_back(mk(ALU_ADD,  0, 3'b0, 0, 0, 0, 0, FWD_M, FWD_NONE, 5, 7, 0, 107, 0, 0, 0));
        vecs.push_back(mk(ALU_ADD,  0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_W, 1, 999, 0, 51, 0, 0, 0));
        vecs.push_back(mk(ALU_SUB,  0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 5, 7, 0, 32'hFFFF_FFFE, 0, 0, 0));
        vecs.push_back(mk(ALU_AND,  0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hF0F0, 32'hFF00, 0, 32'hF000, 0, 0, 0));
        vecs.push_back(mk(ALU_OR,   0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hF0F0, 32'hFF00, 0, 32'hFFF0, 0, 0, 0));
        vecs.push_back(mk(ALU_XOR,  0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hF0F0, 32'hFF00, 0, 32'h0FF0, 0, 0, 0));
        vecs.push_back(mk(ALU_SLL,  0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 1, 36, 0, 32'h10, 0, 0, 0));
        vecs.push_back(mk(ALU_SRL,  0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'h8000_0000, 4, 0, 32'h0800_0000, 0, 0, 0));
        vecs.push_back(mk(ALU_SRA,  0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'h8000_0000, 4, 0, 32'hF800_0000, 0, 0, 0));
        vecs.push_back(mk(ALU_SLT,  0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(ALU_SLTU, 0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(ALU_ADD,  0, 3'b0, 0, 0, 0, 1, FWD_NONE, FWD_NONE, 10, 99, 32'hFFFF_FFFD, 7, 0, 0, 0));
        vecs.push_back(mk(4'd12,    0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 3, 4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(ALU_ADD,  0, BR_BLTU, 1, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hFFFF_FFFF, 1, 32'h20, 0, 0, 0, 0));
        vecs.push_back(mk(ALU_ADD,  0, BR_BLT,  1, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hFFFF_FFFF, 1, 32'h20, 0, 1, 32'h120, 0));
        vecs.push_back(mk(ALU_ADD,  0, BR_BEQ,  1, 0, 0, 0, FWD_NONE, FWD_NONE, 3, 3, 32'h40, 6, 1, 32'h140, 0));
        vecs.push_back(mk(ALU_ADD,  0, BR_BNE,  1, 0, 0, 0, FWD_NONE, FWD_NONE, 3, 3, 32'h40, 6, 0, 0, 0));
        vecs.push_back(mk(ALU_ADD,  0, 3'b0, 0, 1, 1, 1, FWD_NONE, FWD_NONE, 32'h1001, 0, 2, 32'h1003, 1, 32'h1002, 0));
        vecs.push_back(mk(ALU_ADD,  1, MD_DIV,  0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hFFFF_FFEC, 3, 0, 32'hFFFF_FFFA, 0, 0, DIV_BUSY));
        vecs.push_back(mk(ALU_ADD,  1, MD_REM,  0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hFFFF_FFEC, 3, 0, 32'hFFFF_FFFE, 0, 0, DIV_BUSY));
        vecs.push_back(mk(ALU_ADD,  1, MD_DIVU, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 7, 0, 0, 32'hFFFF_FFFF, 0, 0, SPECIAL_BUSY));
        vecs.push_back(mk(ALU_ADD,  1, MD_REMU, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 7, 0, 0, 7, 0, 0, SPECIAL_BUSY));
        vecs.push_back(mk(ALU_ADD,  1, MD_DIV,  0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0, 0, SPECIAL_BUSY));
        vecs.push_back(mk(ALU_ADD,  1, MD_REM,  0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, SPECIAL_BUSY));
        vecs.push_back(mk(ALU_ADD,  1, MD_DIVU, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 100, 7, 0, 14, 0, 0, DIV_BUSY));
        vecs.push_back(mk(ALU_ADD,  1, MD_MULH, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 0, 0, 1));
        vecs.push_back(mk(ALU_ADD,  1, MD_MUL,  0, 1, 0, 0, FWD_NONE, FWD_NONE, 7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB, 0, 0, 1));
        vecs.push_back(mk(ALU_ADD,  1, MD_MULHU, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 0, 0, 1));
        vecs.push_back(mk(ALU_ADD,  1, MD_MULHSU, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'hFFFF_FFFF, 2, 0, 32'hFFFF_FFFF, 0, 0, 1));

        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i], 5'(i + 1), 2'(i));

        // Abort a divide partway through with an asynchronous reset.
        drive(mk(ALU_ADD, 1, MD_DIV, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 32'd1000, 32'd3, 0, 0, 0, 0, 0), 5'd9, 2'd1);
        #1;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
        end
        check("abort.busy_before", {31'b0, bus.md_busyE}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("abort.busy",     {31'b0, bus.md_busyE}, 32'h0);
        check("abort.regwrite", {31'b0, bus.regwriteM}, 32'h0);
        check("abort.rd",       {27'b0, bus.rdM}, 32'h0);
        check("abort.alures",   bus.ALUresM, 32'h0);
        check("abort.pc4",      bus.pc4M, 32'h0);
        bus.mdE = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        v = mk(ALU_ADD, 0, 3'b0, 0, 0, 0, 0, FWD_NONE, FWD_NONE, 3, 4, 0, 7, 0, 0, 0);
        run_op("post_reset_add", v, 5'd3, 2'd2);
        check("post_reset.pc4", bus.pc4M, PC + 32'd4);
        check("scoreboard.left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
